load_store_unit: RTL and testbench

Memory-stage load/store unit of the pipelined core. It consumes the access type produced by the ALU decoder in decode (`Type` = instruction funct3 for loads/stores) and the effective address computed by the ALU. It drives a word-organised synchronous data memory with byte enables, aligns store data, and sign/zero-extends load data. Accesses that straddle a word boundary are split into two memory beats while the pipeline is stalled.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit with byte-lane alignment and load extension.
// Define MISALIGNED_SPLIT_EN to split word-straddling accesses into two beats; otherwise they fault.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [2:0]  Type,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic        Stall,
   output logic        ReadValid,
   output logic [31:0] ReadData,
   output logic        Fault,
   output logic        mem_en,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   logic [1:0]  off;
   logic [3:0]  smask;
   logic        illegal, mis;
   logic        rd_q, rd_d;
   logic [2:0]  rtype_q, rtype_d;
   logic [1:0]  roff_q, roff_d;
   logic [31:0] raw, ext;

   assign off     = Addr[1:0];
   assign smask   = Type[1] ? 4'b1111 : Type[0] ? 4'b0011 : 4'b0001;
   assign illegal = (&Type[1:0]) | (Type[2] & (Type[1] | MemWrite));
   assign mis     = ({1'b0, off} + (Type[1] ? 3'd4 : Type[0] ? 3'd2 : 3'd1)) > 3'd4;

`ifdef MISALIGNED_SPLIT_EN
   typedef enum logic {IDLE, SPLIT} state_t;
   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d, lo_q, lo_d;
   logic        we_q, we_d, split_q, split_d;
   logic [7:0]  be8;
   logic [63:0] wd64;

   // Lane masks and data spanning two words; the upper half is the second beat
   assign be8  = {4'b0000, smask} << off;
   assign wd64 = {32'b0, WriteData} << {off, 3'b000};
   // Beat-1 bytes sit low, beat-2 bytes are placed just above them
   assign raw  = split_q ? (lo_q | (mem_rdata << {2'd0 - roff_q, 3'b000})) : (mem_rdata >> {roff_q, 3'b000});
`else
   assign raw  = mem_rdata >> {roff_q, 3'b000};
`endif

   assign ext       = rtype_q[1] ? raw :
                      rtype_q[0] ? {{16{~rtype_q[2] & raw[15]}}, raw[15:0]} :
                                   {{24{~rtype_q[2] & raw[7]}}, raw[7:0]};
   assign ReadValid = rd_q;
   assign ReadData  = rd_q ? ext : 32'd0;

   // Access decode, memory port drive and next-state; everything is quiet while in reset
   always_comb begin
      rd_d      = 1'b0;
      rtype_d   = rtype_q;
      roff_d    = roff_q;
      Stall     = 1'b0;
      Fault     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
`ifdef MISALIGNED_SPLIT_EN
      state_d   = state_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      lo_d      = lo_q;
      split_d   = 1'b0;
      if (!rst && state_q == SPLIT) begin
         mem_en    = 1'b1;
         mem_we    = we_q;
         mem_addr  = addr_q;
         mem_be    = be_q;
         mem_wdata = wdata_q;
         lo_d      = mem_rdata >> {roff_q, 3'b000};
         rd_d      = ~we_q;
         split_d   = 1'b1;
         state_d   = IDLE;
      end else if (!rst && MemReq) begin
         if (illegal) Fault = 1'b1;
         else begin
            mem_en    = 1'b1;
            mem_we    = MemWrite;
            mem_addr  = Addr[31:2];
            mem_be    = be8[3:0];
            mem_wdata = wd64[31:0];
            rtype_d   = Type;
            roff_d    = off;
            if (mis) begin
               Stall   = 1'b1;
               state_d = SPLIT;
               addr_d  = Addr[31:2] + 30'd1;
               be_d    = be8[7:4];
               wdata_d = wd64[63:32];
               we_d    = MemWrite;
            end else rd_d = ~MemWrite;
         end
      end
`else
      if (!rst && MemReq) begin
         if (illegal || mis) Fault = 1'b1;
         else begin
            mem_en    = 1'b1;
            mem_we    = MemWrite;
            mem_addr  = Addr[31:2];
            mem_be    = smask << off;
            mem_wdata = WriteData << {off, 3'b000};
            rtype_d   = Type;
            roff_d    = off;
            rd_d      = ~MemWrite;
         end
      end
`endif
   end

   // Load-return tracking: which cycle has data and how to extend it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q    <= 1'b0;
         rtype_q <= '0;
         roff_q  <= '0;
      end else begin
         rd_q    <= rd_d;
         rtype_q <= rtype_d;
         roff_q  <= roff_d;
      end

`ifdef MISALIGNED_SPLIT_EN
   // Split state and second-beat holding registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         lo_q    <= '0;
         split_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         lo_q    <= lo_d;
         split_q <= split_d;
      end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemReq = 1'b0, MemWrite = 1'b0;
   logic [2:0]  Type = 3'd0;
   logic [31:0] Addr = 32'd0, WriteData = 32'd0;
   logic        Stall, ReadValid, Fault, mem_en, mem_we;
   logic [31:0] ReadData, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;

   int          checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  dmem [logic [31:0]];
   logic [7:0]  refm [logic [31:0]];
   logic [31:0] last_rd = 32'd0;
   logic [29:0] s1_addr, s2_addr;
   logic [3:0]  s1_be, s2_be;
   logic [31:0] s1_wd, s2_wd;
   logic        s1_fault, s1_stall;

   load_store_unit dut (
      .clk(clk), .rst(rst), .MemReq(MemReq), .MemWrite(MemWrite), .Type(Type), .Addr(Addr),
      .WriteData(WriteData), .Stall(Stall), .ReadValid(ReadValid), .ReadData(ReadData), .Fault(Fault),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dflt(logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] dmem_rd(logic [31:0] a);
      return dmem.exists(a) ? dmem[a] : dflt(a);
   endfunction
   function automatic logic [7:0] ref_rd(logic [31:0] a);
      return refm.exists(a) ? refm[a] : dflt(a);
   endfunction
   function automatic int sz(logic [2:0] t);
      return t[1] ? 4 : t[0] ? 2 : 1;
   endfunction
   function automatic logic is_illegal(logic we, logic [2:0] t);
      return t == 3 || t == 6 || t == 7 || (we && (t == 4 || t == 5));
   endfunction
   function automatic logic [31:0] bmask(logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction
   function automatic logic [31:0] ld_val(logic [31:0] a, logic [2:0] t);
      logic [31:0] v;
      v = 32'd0;
      for (int k = 0; k < sz(t); k++) v[8*k +: 8] = ref_rd(a + 32'(k));
      if (t == 0) v = {{24{v[7]}}, v[7:0]};
      else if (t == 1) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // byte-wise placement of an access across the first and following word
   task automatic lanes(input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd,
                        output logic [3:0] be1, output logic [31:0] w1,
                        output logic [3:0] be2, output logic [31:0] w2);
      logic [31:0] b;
      be1 = 4'd0; be2 = 4'd0; w1 = 32'd0; w2 = 32'd0;
      for (int k = 0; k < sz(t); k++) begin
         b = a + 32'(k);
         if (b[31:2] == a[31:2]) begin
            be1[b[1:0]] = 1'b1;
            w1[8*b[1:0] +: 8] = wd[8*k +: 8];
         end else begin
            be2[b[1:0]] = 1'b1;
            w2[8*b[1:0] +: 8] = wd[8*k +: 8];
         end
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         dmem[a + 32'(i)] = v[8*i +: 8];
         refm[a + 32'(i)] = v[8*i +: 8];
      end
   endtask

   // data memory: byte-enabled writes, one-cycle read latency, garbage when not read
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) dmem[{mem_addr, 2'b00} + 32'(i)] = mem_wdata[8*i +: 8];
         mem_rdata <= $urandom;
      end else if (mem_en)
         mem_rdata <= {dmem_rd({mem_addr, 2'b11}), dmem_rd({mem_addr, 2'b10}),
                       dmem_rd({mem_addr, 2'b01}), dmem_rd({mem_addr, 2'b00})};
      else mem_rdata <= $urandom;
   end

   // monitor: pops the scoreboard whenever a load result appears
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         if (ReadValid) begin
            if (exp_q.size() == 0) chk("readvalid_unexpected", 32'(ReadValid), 32'd0);
            else chk("read_data", ReadData, exp_q.pop_front());
            last_rd = ReadData;
         end else chk("read_data_idle", ReadData, 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         MemReq = 1'b0; MemWrite = 1'($urandom); Type = 3'($urandom);
         Addr = $urandom; WriteData = $urandom;
         #1;
         chk("idle_en", 32'(mem_en), 32'd0);
         chk("idle_fault", 32'(Fault), 32'd0);
         chk("idle_stall", 32'(Stall), 32'd0);
         chk("idle_be", 32'(mem_be), 32'd0);
      end
   endtask

   task automatic access(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
      logic [3:0]  be1, be2;
      logic [31:0] w1, w2, a4;
      logic        ill, mis, flt, spl;
      @(negedge clk);
      MemReq = 1'b1; MemWrite = we; Type = t; Addr = a; WriteData = wd;
      ill = is_illegal(we, t);
      mis = int'(a[1:0]) + sz(t) > 4;
`ifdef MISALIGNED_SPLIT_EN
      spl = !ill && mis;
      flt = ill;
`else
      spl = 1'b0;
      flt = ill || mis;
`endif
      lanes(a, t, wd, be1, w1, be2, w2);
      a4 = a + 32'd4;
      #1;
      s1_addr = mem_addr; s1_be = mem_be; s1_wd = mem_wdata; s1_fault = Fault; s1_stall = Stall;
      chk("fault", 32'(Fault), 32'(flt));
      chk("stall", 32'(Stall), 32'(spl));
      chk("mem_en", 32'(mem_en), 32'(!flt));
      if (flt) chk("fault_be", 32'(mem_be), 32'd0);
      else begin
         chk("mem_we", 32'(mem_we), 32'(we));
         chk("addr1", 32'(mem_addr), 32'(a[31:2]));
         chk("be1", 32'(mem_be), 32'(be1));
         if (we) begin
            chk("wdata1", mem_wdata & bmask(be1), w1);
            for (int k = 0; k < sz(t); k++) refm[a + 32'(k)] = wd[8*k +: 8];
         end else exp_q.push_back(ld_val(a, t));
      end
      if (spl) begin
         @(negedge clk);
         MemReq = 1'($urandom); MemWrite = 1'($urandom); Type = 3'($urandom);
         Addr = $urandom; WriteData = $urandom;
         #1;
         s2_addr = mem_addr; s2_be = mem_be; s2_wd = mem_wdata;
         chk("stall2", 32'(Stall), 32'd0);
         chk("fault2", 32'(Fault), 32'd0);
         chk("mem_en2", 32'(mem_en), 32'd1);
         chk("mem_we2", 32'(mem_we), 32'(we));
         chk("addr2", 32'(mem_addr), 32'(a4[31:2]));
         chk("be2", 32'(mem_be), 32'(be2));
         if (we) chk("wdata2", mem_wdata & bmask(be2), w2);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stall"}, 32'(Stall), 32'd0);
      chk({tag, "_rv"}, 32'(ReadValid), 32'd0);
      chk({tag, "_rd"}, ReadData, 32'd0);
      chk({tag, "_fault"}, 32'(Fault), 32'd0);
      chk({tag, "_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_be"}, 32'(mem_be), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      MemReq = 1'b1; MemWrite = 1'b1; Type = 3'd2; Addr = 32'h100; WriteData = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      #1;
      chk_quiet("rst");
      @(negedge clk);
      rst = 1'b0;
      MemReq = 1'b0;

      poke(32'h100, 32'h80FF1234);
      access(1'b0, 3'd0, 32'h103, 32'd0);
      chk("lb_addr", 32'(s1_addr), 32'h40);
      chk("lb_be", 32'(s1_be), 32'b1000);
      idle(2);
      chk("lb_data", last_rd, 32'hFFFFFF80);
      access(1'b0, 3'd4, 32'h103, 32'd0);
      idle(2);
      chk("lbu_data", last_rd, 32'h00000080);

      access(1'b1, 3'd1, 32'h202, 32'h0000BEEF);
      chk("sh_be", 32'(s1_be), 32'b1100);
      chk("sh_wdata", s1_wd, 32'hBEEF0000);
      chk("sh_stall", 32'(s1_stall), 32'd0);
      idle(1);

`ifdef MISALIGNED_SPLIT_EN
      poke(32'h1FC, 32'h1111AABB);
      poke(32'h200, 32'hCCDD2222);
      access(1'b0, 3'd2, 32'h1FE, 32'd0);
      chk("lw_split_stall", 32'(s1_stall), 32'd1);
      chk("lw_b1_addr", 32'(s1_addr), 32'h7F);
      chk("lw_b1_be", 32'(s1_be), 32'b1100);
      chk("lw_b2_addr", 32'(s2_addr), 32'h80);
      chk("lw_b2_be", 32'(s2_be), 32'b0011);
      idle(2);
      chk("lw_split_data", last_rd, 32'h22221111);

      access(1'b1, 3'd2, 32'hFFFFFFFD, 32'h44332211);
      chk("sw_b1_addr", 32'(s1_addr), 32'h3FFFFFFF);
      chk("sw_b1_be", 32'(s1_be), 32'b1110);
      chk("sw_b1_wdata", s1_wd, 32'h33221100);
      chk("sw_b2_addr", 32'(s2_addr), 32'h0);
      chk("sw_b2_be", 32'(s2_be), 32'b0001);
      chk("sw_b2_wdata", s2_wd, 32'h00000044);
      idle(1);

      @(negedge clk);
      MemReq = 1'b1; MemWrite = 1'b0; Type = 3'd2; Addr = 32'h1FE;
      #1;
      chk("rst_split_stall_pre", 32'(Stall), 32'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_quiet("rst_split");
`else
      access(1'b0, 3'd1, 32'h3, 32'd0);
      chk("lh_mis_fault", 32'(s1_fault), 32'd1);
      chk("lh_mis_stall", 32'(s1_stall), 32'd0);
      idle(1);

      @(negedge clk);
      MemReq = 1'b1; MemWrite = 1'b0; Type = 3'd2; Addr = 32'h1FC;
      #1;
      chk("rst_load_en_pre", 32'(mem_en), 32'd1);
      rst = 1'b1;
      #1;
      chk_quiet("rst_load");
`endif
      @(negedge clk);
      #1;
      chk_quiet("rst_hold");
      rst = 1'b0;
      MemReq = 1'b0;
      idle(3);

      access(1'b0, 3'd3, 32'h100, 32'd0);
      chk("type011_fault", 32'(s1_fault), 32'd1);
      idle(1);

      for (int n = 0; n < 400; n++) begin
         logic [2:0]  t;
         logic [31:0] a;
         int          r;
         r = $urandom_range(0, 19);
         if (r == 0) t = 3'd3;
         else if (r == 1) t = 3'($urandom_range(6, 7));
         else begin
            r = $urandom_range(0, 4);
            t = r == 0 ? 3'd0 : r == 1 ? 3'd1 : r == 2 ? 3'd2 : r == 3 ? 3'd4 : 3'd5;
         end
         a = $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 + 32'($urandom_range(0, 31))
                                       : 32'h1000 + 32'($urandom_range(0, 31));
         access(1'($urandom), t, a, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      foreach (refm[k]) chk("mem_byte", 32'(dmem_rd(k)), 32'(refm[k]));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
